id_ex_stage: RTL

//   ID->EX pipeline register and operand-select stage directly upstream of the ALU.

---
 rtl/id_ex_stage_pkg.sv | 21 ++
 rtl/id_ex_stage_if.sv | 56 +++++
 rtl/id_ex_stage_operand_fwd.sv | 41 ++++
 rtl/id_ex_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU op codes and forwarding-select encoding for the ID->EX stage.
package id_ex_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REGW  = 5;
    localparam int unsigned CTRLW = 3;
    localparam int unsigned CNTW  = 16;

    localparam logic [CTRLW-1:0] ALU_ADD = 3'd0;
    localparam logic [CTRLW-1:0] ALU_SUB = 3'd1;
    localparam logic [CTRLW-1:0] ALU_AND = 3'd2;
    localparam logic [CTRLW-1:0] ALU_SLL = 3'd3;

    // Which source feeds an ALU operand this cycle
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side, forwarding-side and EX-side signals of the ID->EX stage.
interface id_ex_stage_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned REGW  = 5,
    parameter int unsigned CTRLW = 3,
    parameter int unsigned CNTW  = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [REGW-1:0]  id_rs1;
    logic [REGW-1:0]  id_rs2;
    logic [REGW-1:0]  id_rd;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic             id_alu_src;
    logic [CTRLW-1:0] id_alu_ctrl;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             flush;
    logic             ex_stall;
    logic [REGW-1:0]  mem_rd;
    logic             mem_reg_write;
    logic [XLEN-1:0]  mem_result;
    logic [REGW-1:0]  wb_rd;
    logic             wb_reg_write;
    logic [XLEN-1:0]  wb_result;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_op_a;
    logic [XLEN-1:0]  ex_op_b;
    logic [XLEN-1:0]  ex_store_data;
    logic [CTRLW-1:0] ex_alu_ctrl;
    logic [REGW-1:0]  ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [CNTW-1:0]  stall_count;

    // Decode / pipeline-control side
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, flush, ex_stall,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        input  id_ready, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_alu_ctrl,
               ex_rd, ex_reg_write, ex_mem_read, stall_count
    );

    // The ID->EX stage itself
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
               id_alu_src, id_alu_ctrl, id_reg_write, id_mem_read, flush, ex_stall,
               mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
        output id_ready, ex_valid, ex_op_a, ex_op_b, ex_store_data, ex_alu_ctrl,
               ex_rd, ex_reg_write, ex_mem_read, stall_count
    );

endinterface

// File: rtl/id_ex_stage_operand_fwd.sv
// Priority operand select for one ALU source: EX/MEM beats MEM/WB beats the
// registered value; register x0 is never forwarded.
module operand_fwd #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] i_rs,
    input  logic [XLEN-1:0] i_reg_val,
    input  logic [REGW-1:0] i_mem_rd,
    input  logic            i_mem_we,
    input  logic [XLEN-1:0] i_mem_val,
    input  logic [REGW-1:0] i_wb_rd,
    input  logic            i_wb_we,
    input  logic [XLEN-1:0] i_wb_val,
    output logic [XLEN-1:0] o_val
);
    import id_ex_stage_pkg::*;

    fwd_sel_e w_sel;

    // Pick the youngest in-flight producer of i_rs
    always_comb begin
        w_sel = FWD_REG;
        if (i_mem_we && (i_mem_rd != '0) && (i_mem_rd == i_rs)) begin
            w_sel = FWD_MEM;
        end else if (i_wb_we && (i_wb_rd != '0) && (i_wb_rd == i_rs)) begin
            w_sel = FWD_WB;
        end
    end

    // Steer the selected source onto the operand
    always_comb begin
        o_val = i_reg_val;
        unique case (w_sel)
            FWD_MEM: o_val = i_mem_val;
            FWD_WB:  o_val = i_wb_val;
            default: o_val = i_reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures decoded instructions, detects load-use
// hazards, honours flush/stall, forwards operands and counts load-use stalls.
module id_ex_stage #(
    parameter int unsigned XLEN  = id_ex_stage_pkg::XLEN,
    parameter int unsigned REGW  = id_ex_stage_pkg::REGW,
    parameter int unsigned CTRLW = id_ex_stage_pkg::CTRLW,
    parameter int unsigned CNTW  = id_ex_stage_pkg::CNTW
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    import id_ex_stage_pkg::*;

    logic             r_valid;
    logic [REGW-1:0]  r_rs1;
    logic [REGW-1:0]  r_rs2;
    logic [REGW-1:0]  r_rd;
    logic [XLEN-1:0]  r_rs1_val;
    logic [XLEN-1:0]  r_rs2_val;
    logic [XLEN-1:0]  r_imm;
    logic             r_alu_src;
    logic [CTRLW-1:0] r_alu_ctrl;
    logic             r_reg_write;
    logic             r_mem_read;
    logic [CNTW-1:0]  r_stall_cnt;

    logic             w_luh;
    logic [XLEN-1:0]  w_cap_rs1;
    logic [XLEN-1:0]  w_cap_rs2;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    // Load in EX whose destination the decode instruction reads (rs2 only matters without imm)
    always_comb begin
        w_luh = r_valid && r_mem_read && (r_rd != '0) && bus.id_valid &&
                ((r_rd == bus.id_rs1) || ((r_rd == bus.id_rs2) && !bus.id_alu_src));
    end

    assign bus.id_ready = !bus.ex_stall && !w_luh;

    // Register-file write happening this cycle is not yet visible in id_rsN_data
    always_comb begin
        w_cap_rs1 = bus.id_rs1_data;
        w_cap_rs2 = bus.id_rs2_data;
        if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs1)) begin
            w_cap_rs1 = bus.wb_result;
        end
        if (bus.wb_reg_write && (bus.wb_rd != '0) && (bus.wb_rd == bus.id_rs2)) begin
            w_cap_rs2 = bus.wb_result;
        end
    end

    // EX register: flush > stall > load-use bubble > capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_rs1_val   <= '0;
            r_rs2_val   <= '0;
            r_imm       <= '0;
            r_alu_src   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (bus.ex_stall) begin
            r_valid <= r_valid;
        end else if (w_luh) begin
            r_valid <= 1'b0;
        end else begin
            r_valid     <= bus.id_valid;
            r_rs1       <= bus.id_rs1;
            r_rs2       <= bus.id_rs2;
            r_rd        <= bus.id_rd;
            r_rs1_val   <= w_cap_rs1;
            r_rs2_val   <= w_cap_rs2;
            r_imm       <= bus.id_imm;
            r_alu_src   <= bus.id_alu_src;
            r_alu_ctrl  <= bus.id_alu_ctrl;
            r_reg_write <= bus.id_reg_write;
            r_mem_read  <= bus.id_mem_read;
        end
    end

    // Saturating count of cycles actually spent as load-use bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!bus.flush && !bus.ex_stall && w_luh && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    operand_fwd #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .i_rs      (r_rs1),
        .i_reg_val (r_rs1_val),
        .i_mem_rd  (bus.mem_rd),
        .i_mem_we  (bus.mem_reg_write),
        .i_mem_val (bus.mem_result),
        .i_wb_rd   (bus.wb_rd),
        .i_wb_we   (bus.wb_reg_write),
        .i_wb_val  (bus.wb_result),
        .o_val     (w_fwd_rs1)
    );

    operand_fwd #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .i_rs      (r_rs2),
        .i_reg_val (r_rs2_val),
        .i_mem_rd  (bus.mem_rd),
        .i_mem_we  (bus.mem_reg_write),
        .i_mem_val (bus.mem_result),
        .i_wb_rd   (bus.wb_rd),
        .i_wb_we   (bus.wb_reg_write),
        .i_wb_val  (bus.wb_result),
        .o_val     (w_fwd_rs2)
    );

    assign bus.ex_valid      = r_valid;
    assign bus.ex_op_a       = w_fwd_rs1;
    assign bus.ex_op_b       = r_alu_src ? r_imm : w_fwd_rs2;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ex_alu_ctrl   = r_alu_ctrl;
    assign bus.ex_rd         = r_rd;
    assign bus.ex_reg_write  = r_reg_write;
    assign bus.ex_mem_read   = r_mem_read;
    assign bus.stall_count   = r_stall_cnt;

endmodule
